// File: rtl/btn_pkg.sv
// Shared types and helpers for the button event decoder.
package btn_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StPressed,
      StLong
   } btn_state_e;

   // Width that holds every count up to max(a, b) - 1; never narrower than 1 bit.
   function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
      int unsigned m;
      int unsigned w;
      m = (a > b) ? a : b;
      w = $clog2(m);
      return (w == 0) ? 1 : w;
   endfunction

endpackage

// File: rtl/button_events.sv
// Turns a debounced button level into one-cycle press/release/click/long/repeat strobes.
module button_events
   import btn_pkg::*;
#(
   parameter int unsigned LONG_CYCLES   = 12_500_000,
   parameter int unsigned REPEAT_CYCLES = 2_500_000,
   parameter int unsigned REPEAT_EN     = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic level,
   output logic held,
   output logic press_pulse,
   output logic release_pulse,
   output logic click,
   output logic long_pulse,
   output logic repeat_pulse
);

   localparam int unsigned CntW = cnt_width(LONG_CYCLES, REPEAT_CYCLES);
   localparam logic [CntW-1:0] LongLast = CntW'(LONG_CYCLES - 1);
   localparam logic [CntW-1:0] RepLast  = CntW'(REPEAT_CYCLES - 1);

   if (LONG_CYCLES < 2) begin : g_bad_long
      $error("button_events: LONG_CYCLES must be >= 2");
   end
   if (REPEAT_CYCLES < 1) begin : g_bad_repeat
      $error("button_events: REPEAT_CYCLES must be >= 1");
   end
   if (REPEAT_EN > 1) begin : g_bad_repeat_en
      $error("button_events: REPEAT_EN must be 0 or 1");
   end

   btn_state_e    state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic          level_q;
   logic          press_q, press_d;
   logic          release_q, release_d;
   logic          click_q, click_d;
   logic          long_q, long_d;
   logic          repeat_q, repeat_d;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      click_d   = 1'b0;
      long_d    = 1'b0;
      repeat_d  = 1'b0;
      case (state_q)
         StIdle: begin
            if (level && !level_q) begin
               press_d = 1'b1;
               cnt_d   = '0;
               state_d = StPressed;
            end
         end
         StPressed: begin
            // Release is checked first so it beats a coincident terminal count.
            if (!level) begin
               release_d = 1'b1;
               click_d   = 1'b1;
               cnt_d     = '0;
               state_d   = StIdle;
            end else if (cnt_q == LongLast) begin
               long_d  = 1'b1;
               cnt_d   = '0;
               state_d = StLong;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StLong: begin
            if (!level) begin
               release_d = 1'b1;
               cnt_d     = '0;
               state_d   = StIdle;
            end else if (REPEAT_EN != 0) begin
               if (cnt_q == RepLast) begin
                  repeat_d = 1'b1;
                  cnt_d    = '0;
               end else begin
                  cnt_d = cnt_q + CntW'(1);
               end
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         level_q   <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
         click_q   <= 1'b0;
         long_q    <= 1'b0;
         repeat_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         level_q   <= level;
         press_q   <= press_d;
         release_q <= release_d;
         click_q   <= click_d;
         long_q    <= long_d;
         repeat_q  <= repeat_d;
      end
   end

   assign held          = level_q;
   assign press_pulse   = press_q;
   assign release_pulse = release_q;
   assign click         = click_q;
   assign long_pulse    = long_q;
   assign repeat_pulse  = repeat_q;

endmodule

// File: tb/tb_button_events.sv
// Randomized bench: two instances (repeat on/off) checked against an age-based press model.
module tb_button_events;

   localparam int unsigned L = 8;
   localparam int unsigned R = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic level = 1'b0;

   logic held_a, press_a, release_a, click_a, long_a, repeat_a;
   logic held_b, press_b, release_b, click_b, long_b, repeat_b;

   always #5 clk = ~clk;

   button_events #(
      .LONG_CYCLES  (L),
      .REPEAT_CYCLES(R),
      .REPEAT_EN    (1)
   ) u_dut_rep (
      .clk          (clk),
      .rst_n        (rst_n),
      .level        (level),
      .held         (held_a),
      .press_pulse  (press_a),
      .release_pulse(release_a),
      .click        (click_a),
      .long_pulse   (long_a),
      .repeat_pulse (repeat_a)
   );

   button_events #(
      .LONG_CYCLES  (L),
      .REPEAT_CYCLES(R),
      .REPEAT_EN    (0)
   ) u_dut_norep (
      .clk          (clk),
      .rst_n        (rst_n),
      .level        (level),
      .held         (held_b),
      .press_pulse  (press_b),
      .release_pulse(release_b),
      .click        (click_b),
      .long_pulse   (long_b),
      .repeat_pulse (repeat_b)
   );

   // Bit order: held, press, release, click, long, repeat.
   wire [5:0] obs_a = {held_a, press_a, release_a, click_a, long_a, repeat_a};
   wire [5:0] obs_b = {held_b, press_b, release_b, click_b, long_b, repeat_b};

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;
   string phase = "init";

   bit          m_pressed [2];
   int unsigned m_age     [2];
   logic [5:0]  m_exp     [2];
   bit          m_rep_en  [2] = '{1'b1, 1'b0};

   task automatic check_eq(input string tag, input logic [5:0] obs, input logic [5:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s @cyc %0d (%s): got %b expected %b", tag, cyc, phase, obs, exp);
      end
   endtask

   // Age = edges since the press edge while the button stays down.
   task automatic model_step(input int i, input logic lvl);
      logic [5:0] e;
      e    = '0;
      e[5] = lvl;
      if (!m_pressed[i]) begin
         if (lvl) begin
            e[4]         = 1'b1;
            m_pressed[i] = 1'b1;
            m_age[i]     = 0;
         end
      end else if (lvl) begin
         m_age[i]++;
         if (m_age[i] == L) e[1] = 1'b1;
         else if (m_rep_en[i] && m_age[i] > L && ((m_age[i] - L) % R) == 0) e[0] = 1'b1;
      end else begin
         e[3]         = 1'b1;
         e[2]         = (m_age[i] < L);
         m_pressed[i] = 1'b0;
      end
      m_exp[i] = e;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_pressed[i] = 1'b0;
         m_age[i]     = 0;
         m_exp[i]     = '0;
      end
   endtask

   task automatic cycle(input logic lvl);
      @(negedge clk);
      level = lvl;
      model_step(0, lvl);
      model_step(1, lvl);
      @(posedge clk);
      #1;
      cyc++;
      check_eq("rep", obs_a, m_exp[0]);
      check_eq("norep", obs_b, m_exp[1]);
   endtask

   task automatic run(input logic lvl, input int n);
      for (int k = 0; k < n; k++) cycle(lvl);
   endtask

   // Asynchronous reset mid-cycle; level is left as is, release lands before the next negedge.
   task automatic async_reset();
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check_eq("rst_rep", obs_a, 6'b0);
      check_eq("rst_norep", obs_b, 6'b0);
      model_reset();
      rst_n = 1'b1;
   endtask

   initial begin
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      phase = "reset";
      check_eq("rst_rep", obs_a, 6'b0);
      check_eq("rst_norep", obs_b, 6'b0);
      rst_n = 1'b1;

      phase = "idle";
      run(1'b0, 5);
      phase = "short";
      run(1'b1, 3);
      run(1'b0, 3);
      phase = "long_repeat";
      run(1'b1, 21);
      run(1'b0, 2);
      phase = "collision";
      run(1'b1, L);
      run(1'b0, 2);
      phase = "rapid";
      cycle(1'b1);
      cycle(1'b0);
      cycle(1'b1);
      cycle(1'b0);
      run(1'b0, 2);
      phase = "hold40";
      run(1'b1, 40);
      run(1'b0, 2);
      phase = "reset_mid_hold";
      run(1'b1, 20);
      async_reset();
      run(1'b1, 12);
      run(1'b0, 2);

      phase = "random";
      for (int p = 0; p < 120; p++) begin
         int hi;
         hi = $urandom_range(1, 30);
         if ($urandom_range(0, 9) == 0 && hi > 2) begin
            run(1'b1, hi / 2);
            async_reset();
            run(1'b1, hi - hi / 2);
         end else begin
            run(1'b1, hi);
         end
         run(1'b0, $urandom_range(1, 4));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
